// File: rtl/hi_lo_register_unit.sv
// HI/LO architectural register pair: commits multiply, divide and move results
// and serves MFHI/MFLO reads with same-cycle forwarding and divide stalls.
module hi_lo_register_unit #(
   parameter int CPU_DATA_WIDTH = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          write_valid,
   input  logic                          multiply_valid,
   input  logic [2*CPU_DATA_WIDTH-1:0]   multiply_result,
   input  logic                          divide_issue,
   input  logic                          divide_result_valid,
   input  logic [CPU_DATA_WIDTH-1:0]     divide_result,
   input  logic [CPU_DATA_WIDTH-1:0]     divide_remain,
   input  logic                          high_low_write,
   input  logic                          result_high,
   input  logic                          result_low,
   input  logic [CPU_DATA_WIDTH-1:0]     move_data,
   output logic                          write_ready,
   input  logic                          read_request,
   input  logic                          read_high,
   output logic                          read_ready,
   output logic [CPU_DATA_WIDTH-1:0]     read_data,
   output logic [CPU_DATA_WIDTH-1:0]     high,
   output logic [CPU_DATA_WIDTH-1:0]     low,
   output logic                          divide_pending
);

   // state   | meaning
   // IDLE    | no divide outstanding; writers accepted
   // PENDING | divide issued, waiting for the divider's result pulse
   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic writer;
   logic accept;
   logic accept_multiply;
   logic accept_move;
   logic accept_divide;
   logic commit_divide;

   assign divide_pending  = (state == PENDING);
   assign write_ready     = ~divide_pending;
   assign writer          = write_valid & (multiply_valid | divide_issue | high_low_write);
   assign accept          = writer & write_ready;
   assign accept_multiply = accept & multiply_valid;
   assign accept_move     = accept & ~multiply_valid & high_low_write;
   assign accept_divide   = accept & ~multiply_valid & ~high_low_write & divide_issue;
   assign commit_divide   = divide_pending & divide_result_valid;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept_divide) state_next = PENDING;
         PENDING: if (divide_result_valid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A divide commit and an accepted writer can never coincide: writers are
   // only accepted while no divide is outstanding.
   always_ff @(posedge clock) begin
      if (reset) begin
         high <= '0;
         low  <= '0;
      end else if (commit_divide) begin
         high <= divide_remain;
         low  <= divide_result;
      end else if (accept_multiply) begin
         high <= multiply_result[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH];
         low  <= multiply_result[CPU_DATA_WIDTH-1:0];
      end else if (accept_move) begin
         if (result_high) high <= move_data;
         if (result_low)  low  <= move_data;
      end
   end

   always_comb begin
      read_ready = 1'b1;
      read_data  = '0;
      if (read_request) begin
         if (commit_divide) begin
            read_data = read_high ? divide_remain : divide_result;
         end else if (divide_pending) begin
            read_ready = 1'b0;
         end else if (accept_multiply) begin
            read_data = read_high ? multiply_result[2*CPU_DATA_WIDTH-1:CPU_DATA_WIDTH]
                                  : multiply_result[CPU_DATA_WIDTH-1:0];
         end else if (accept_move && (read_high ? result_high : result_low)) begin
            read_data = move_data;
         end else begin
            read_data = read_high ? high : low;
         end
      end
   end

endmodule

// File: tb/tb_hi_lo_register_unit.sv
// Directed bench for hi_lo_register_unit: a sequential vector table plus a
// hand-written reset-during-divide sequence.
module tb_hi_lo_register_unit;

   logic        clock;
   logic        reset;
   logic        write_valid;
   logic        multiply_valid;
   logic [63:0] multiply_result;
   logic        divide_issue;
   logic        divide_result_valid;
   logic [31:0] divide_result;
   logic [31:0] divide_remain;
   logic        high_low_write;
   logic        result_high;
   logic        result_low;
   logic [31:0] move_data;
   logic        write_ready;
   logic        read_request;
   logic        read_high;
   logic        read_ready;
   logic [31:0] read_data;
   logic [31:0] high;
   logic [31:0] low;
   logic        divide_pending;

   int checks = 0;
   int errors = 0;

   hi_lo_register_unit #(.CPU_DATA_WIDTH(32)) dut (
      .clock               (clock),
      .reset               (reset),
      .write_valid         (write_valid),
      .multiply_valid      (multiply_valid),
      .multiply_result     (multiply_result),
      .divide_issue        (divide_issue),
      .divide_result_valid (divide_result_valid),
      .divide_result       (divide_result),
      .divide_remain       (divide_remain),
      .high_low_write      (high_low_write),
      .result_high         (result_high),
      .result_low          (result_low),
      .move_data           (move_data),
      .write_ready         (write_ready),
      .read_request        (read_request),
      .read_high           (read_high),
      .read_ready          (read_ready),
      .read_data           (read_data),
      .high                (high),
      .low                 (low),
      .divide_pending      (divide_pending)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        rst;
      logic        wv;
      logic        mv;
      logic [63:0] mr;
      logic        di;
      logic        drv;
      logic [31:0] dres;
      logic [31:0] drem;
      logic        hlw;
      logic        rh;
      logic        rl;
      logic [31:0] md;
      logic        rreq;
      logic        rhigh;
      logic        e_wr;
      logic        e_rr;
      logic [31:0] e_rd;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      logic        e_pend;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, logic rst, logic wv, logic mv, logic [63:0] mr,
                               logic di, logic drv, logic [31:0] dres, logic [31:0] drem,
                               logic hlw, logic rh, logic rl, logic [31:0] md,
                               logic rreq, logic rhigh, logic e_wr, logic e_rr,
                               logic [31:0] e_rd, logic [31:0] e_hi, logic [31:0] e_lo,
                               logic e_pend);
      vec_t v;
      v.name = name; v.rst = rst; v.wv = wv; v.mv = mv; v.mr = mr; v.di = di;
      v.drv = drv; v.dres = dres; v.drem = drem; v.hlw = hlw; v.rh = rh; v.rl = rl;
      v.md = md; v.rreq = rreq; v.rhigh = rhigh; v.e_wr = e_wr; v.e_rr = e_rr;
      v.e_rd = e_rd; v.e_hi = e_hi; v.e_lo = e_lo; v.e_pend = e_pend;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic drive(vec_t v);
      reset               = v.rst;
      write_valid         = v.wv;
      multiply_valid      = v.mv;
      multiply_result     = v.mr;
      divide_issue        = v.di;
      divide_result_valid = v.drv;
      divide_result       = v.dres;
      divide_remain       = v.drem;
      high_low_write      = v.hlw;
      result_high         = v.rh;
      result_low          = v.rl;
      move_data           = v.md;
      read_request        = v.rreq;
      read_high           = v.rhigh;
   endtask

   task automatic idle_inputs();
      drive(mk("idle", 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
   endtask

   // Inputs change 1 time unit after a rising edge, combinational outputs are
   // sampled 3 units later, registered outputs 1 unit after the next edge.
   task automatic run_vec(vec_t v);
      drive(v);
      #3;
      check({v.name, ".write_ready"}, 64'(write_ready), 64'(v.e_wr));
      check({v.name, ".read_ready"},  64'(read_ready),  64'(v.e_rr));
      check({v.name, ".read_data"},   64'(read_data),   64'(v.e_rd));
      @(posedge clock);
      #1;
      check({v.name, ".high"},           64'(high),           64'(v.e_hi));
      check({v.name, ".low"},            64'(low),            64'(v.e_lo));
      check({v.name, ".divide_pending"}, 64'(divide_pending), 64'(v.e_pend));
   endtask

   localparam logic [63:0] MR1 = 64'h0000_0001_FFFF_FFFE;
   localparam logic [63:0] MR2 = 64'hAAAA_BBBB_CCCC_DDDD;

   initial begin
      //          name          rst wv mv mr   di drv dres   drem   hlw rh rl md            rreq rhi  wr rr rd            hi            lo            pend
      vecs.push_back(mk("rst_hold",  1, 0, 0, 0,   0, 0, 0,     0,     0, 0, 0, 0,            1, 1,    1, 1, 0,            0,            0,            0));
      vecs.push_back(mk("idle_mfhi", 0, 0, 0, 0,   0, 0, 0,     0,     0, 0, 0, 0,            1, 1,    1, 1, 0,            0,            0,            0));
      vecs.push_back(mk("mult_fwd",  0, 1, 1, MR1, 0, 0, 0,     0,     0, 0, 0, 0,            1, 0,    1, 1, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 0));
      vecs.push_back(mk("mfhi",      0, 0, 0, 0,   0, 0, 0,     0,     0, 0, 0, 0,            1, 1,    1, 1, 32'h00000001, 32'h00000001, 32'hFFFFFFFE, 0));
      vecs.push_back(mk("mthi",      0, 1, 0, 0,   0, 0, 0,     0,     1, 1, 0, 32'h12345678, 1, 1,    1, 1, 32'h12345678, 32'h12345678, 32'hFFFFFFFE, 0));
      vecs.push_back(mk("mtlo",      0, 1, 0, 0,   0, 0, 0,     0,     1, 0, 1, 32'h9ABCDEF0, 1, 1,    1, 1, 32'h12345678, 32'h12345678, 32'h9ABCDEF0, 0));
      vecs.push_back(mk("wv_off",    0, 0, 1, MR2, 0, 0, 0,     0,     0, 0, 0, 0,            1, 0,    1, 1, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 0));
      vecs.push_back(mk("stray_res", 0, 0, 0, 0,   0, 1, 32'h55, 32'h66, 0, 0, 0, 0,            1, 1,    1, 1, 32'h12345678, 32'h12345678, 32'h9ABCDEF0, 0));
      vecs.push_back(mk("no_read",   0, 0, 0, 0,   0, 0, 0,     0,     0, 0, 0, 0,            0, 1,    1, 1, 0,            32'h12345678, 32'h9ABCDEF0, 0));
      vecs.push_back(mk("div_issue", 0, 1, 0, 0,   1, 0, 0,     0,     0, 0, 0, 0,            0, 0,    1, 1, 0,            32'h12345678, 32'h9ABCDEF0, 1));
      for (int i = 1; i <= 5; i++)
         vecs.push_back(mk($sformatf("div_wait%0d", i),
                                     0, 1, 1, MR2, 0, 0, 0,     0,     0, 0, 0, 0,            1, 1,    0, 0, 0,            32'h12345678, 32'h9ABCDEF0, 1));
      vecs.push_back(mk("div_pulse", 0, 1, 1, MR2, 0, 1, 7,     3,     0, 0, 0, 0,            1, 1,    0, 1, 32'h3,        32'h3,        32'h7,        0));
      vecs.push_back(mk("mult_held", 0, 1, 1, MR2, 0, 0, 0,     0,     0, 0, 0, 0,            1, 0,    1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 32'hCCCCDDDD, 0));
      vecs.push_back(mk("div2_iss",  0, 1, 0, 0,   1, 0, 0,     0,     0, 0, 0, 0,            1, 0,    1, 1, 32'hCCCCDDDD, 32'hAAAABBBB, 32'hCCCCDDDD, 1));
      vecs.push_back(mk("div2_mflo", 0, 0, 0, 0,   0, 1, 32'h11, 32'h22, 0, 0, 0, 0,            1, 0,    0, 1, 32'h11,       32'h22,       32'h11,       0));

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset while a divide is outstanding, followed by a late result pulse.
      drive(mk("rd_issue", 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
      @(posedge clock); #1;
      check("rd.pending_set", 64'(divide_pending), 64'd1);
      idle_inputs();
      reset = 1'b1;
      @(posedge clock); #1;
      check("rd.pending_clr", 64'(divide_pending), 64'd0);
      check("rd.high_zero",   64'(high),           64'd0);
      check("rd.low_zero",    64'(low),            64'd0);
      reset               = 1'b0;
      divide_result_valid = 1'b1;
      divide_result       = 32'hDEAD0001;
      divide_remain       = 32'hDEAD0002;
      read_request        = 1'b1;
      read_high           = 1'b1;
      #3;
      check("rd.late_rready", 64'(read_ready), 64'd1);
      check("rd.late_rdata",  64'(read_data),  64'd0);
      @(posedge clock); #1;
      check("rd.late_pending", 64'(divide_pending), 64'd0);
      check("rd.late_high",    64'(high),           64'd0);
      check("rd.late_low",     64'(low),            64'd0);
      check("rd.write_ready",  64'(write_ready),    64'd1);
      idle_inputs();
      @(posedge clock); #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hi_lo_register_unit.md
# hi_lo_register_unit

Architectural HI/LO register pair for the MIPS core: the consuming end of the multiply/divide result path carried from EX through IO. It commits MULT/MULTU products, DIV/DIVU quotient/remainder pairs and MTHI/MTLO moves. It also serves MFHI/MFLO reads from EX, with same-cycle forwarding and stalls while a divide is outstanding.

## Interface
- CPU_DATA_WIDTH, 32, width of HI, LO and all data ports; multiply_result is 2*CPU_DATA_WIDTH.
- clock  in  1  single core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- write_valid  in  1  IO-stage instruction is valid and commits this cycle.
- multiply_valid  in  1  committing instruction is MULT/MULTU.
- multiply_result  in  64  product; [63:32] goes to HI, [31:0] goes to LO.
- divide_issue  in  1  committing instruction is DIV/DIVU; result arrives later.
- divide_result_valid  in  1  one-cycle pulse from divider: result ready.
- divide_result  in  32  quotient, goes to LO.
- divide_remain  in  32  remainder, goes to HI.
- high_low_write  in  1  committing instruction is MTHI/MTLO.
- result_high  in  1  MTHI target select; result_low selects MTLO. Exactly one is set when high_low_write=1.
- result_low  in  1  see result_high.
- move_data  in  32  MTHI/MTLO source value.
- write_ready  out  1  unit accepts a HI/LO writer this cycle.
- read_request  in  1  EX-stage MFHI/MFLO present.
- read_high  in  1  1 = read HI, 0 = read LO.
- read_ready  out  1  read_data is valid this cycle; 0 means EX must stall.
- read_data  out  32  MFHI/MFLO value, 0 when read_request=0.
- high, low  out  32 each  committed HI/LO register contents.
- divide_pending  out  1  a divide has issued and its result has not yet been committed.

## Operation
- Writer: write_valid AND (multiply_valid OR divide_issue OR high_low_write). Exactly one kind is set per writer.
- write_ready = NOT divide_pending. A writer presented while write_ready=0 is not accepted; IO holds it.
- Accepted multiply: HI <= multiply_result[63:32], LO <= multiply_result[31:0].
- Accepted MTHI: HI <= move_data, LO unchanged. Accepted MTLO: LO <= move_data, HI unchanged.
- Accepted divide_issue: divide_pending <= 1; HI/LO unchanged.
- divide_result_valid while divide_pending=1: HI <= divide_remain, LO <= divide_result, divide_pending <= 0.
- divide_result_valid while divide_pending=0 is ignored. This covers stale results after reset.
- State machine (divide_pending bit):
  - IDLE -> PENDING on accepted divide_issue.
  - PENDING -> IDLE on divide_result_valid.
  - Any state -> IDLE on reset.
- Read path, combinational, with priority:
  1. If divide_pending and divide_result_valid: forward divide_remain for HI, divide_result for LO. read_ready=1.
  2. If divide_pending and no result: read_ready=0, read_data=0.
  3. If an accepted multiply or MTHI/MTLO writes the selected register this cycle: forward the written value. read_ready=1.
  4. Otherwise: return the committed HI/LO. read_ready=1.
- read_ready=1 whenever read_request=0.
- Arithmetic: no computation; field slicing only. Widths are exact, with no sign or zero extension.

## Timing
- Reset values: high=0, low=0, divide_pending=0, write_ready=1, read_ready=1, read_data=0.
- Write latency: 1 cycle. A value accepted at edge N is visible on high/low after edge N. It is visible on read_data in the same cycle via forwarding.
- Divide: issue accepted at edge N. divide_pending=1 from N+1. A result pulse at cycle M commits at edge M+1; divide_pending=0 from M+1.
- Result pulse and a new writer in the same cycle: writer is refused (write_ready=0) and accepted next cycle. The ordering is therefore divide result, then the new writer.
- Reset mid-divide: pending cleared; any later divide_result_valid is dropped; HI/LO return to 0.
- write_valid=0 overrides all writer qualifiers.

## Test plan
- Reset, then idle: high=0, low=0, read_ready=1, write_ready=1. A read with read_high=1 returns 0.
- MULT with result 0x00000001_FFFFFFFE: after one edge high=0x00000001, low=0xFFFFFFFE. A same-cycle MFLO read forwards 0xFFFFFFFE.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0: high=0x12345678, low=0x9ABCDEF0. The second write leaves HI unchanged.
- DIV issue, result after 5 cycles (quotient 7, remainder 3):
  - During cycles 1-5: divide_pending=1, MFHI read_ready=0, a MULT writer sees write_ready=0.
  - In the pulse cycle: MFHI forwards 3.
  - Next cycle: low=7, high=3, and the stalled MULT is accepted.
- Reset asserted during a pending divide, then a divide_result_valid pulse: divide_pending=0 and high/low stay 0.
- Stray divide_result_valid with no divide pending: high/low are unchanged and read_ready stays 1.
